// File: rtl/tlk2711_rx_frame.sv
// TLK2711 receive frame decoder: comma-based link sync, SOF/length/payload/checksum/EOF
// delineation, payload streaming with per-frame done/error pulses and saturating counters.
module tlk2711_rx_frame #(
   parameter int unsigned MAX_LEN  = 1024,
   parameter int unsigned SYNC_CNT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_soft_rst,
   input  logic        i_rx_valid,
   input  logic [17:0] i_rx_data,
   output logic        o_link_up,
   output logic [15:0] o_data,
   output logic        o_data_valid,
   output logic        o_sof,
   output logic        o_eof,
   output logic        o_frame_done,
   output logic        o_frame_err,
   output logic [1:0]  o_err_code,
   output logic [31:0] o_frame_cnt,
   output logic [15:0] o_err_cnt
);

   localparam int unsigned DW = 16;
   localparam int unsigned CW = 8;
   localparam logic [1:0]  ERR_LEN = 2'd1;
   localparam logic [1:0]  ERR_CHK = 2'd2;
   localparam logic [1:0]  ERR_FRM = 2'd3;

   typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CHK, S_EOF} state_t;

   state_t          state, state_d;
   logic [1:0]      rk;
   logic [DW-1:0]   dat;
   logic            is_k, is_idle, is_sof, is_eof, is_errw, is_bad;
   logic [CW-1:0]   comma_cnt, comma_d;
   logic            link_d;
   logic [DW-1:0]   rem, csum;
   logic            first;
   logic            err_c, done_c, emit_c, load_c;
   logic [1:0]      code_c;
   logic [DW-1:0]   data_d;
   logic            dv_d, sof_d, eof_d, done_d, err_d;
   logic [1:0]      code_d;
   logic [31:0]     fcnt_d;
   logic [15:0]     ecnt_d;

   // Character classification
   assign rk      = i_rx_data[17:16];
   assign dat     = i_rx_data[15:0];
   assign is_k    = |rk;
   assign is_idle = (rk == 2'b01) && (dat == 16'hC5BC);
   assign is_sof  = (rk == 2'b01) && (dat == 16'h00FB);
   assign is_eof  = (rk == 2'b01) && (dat == 16'h00FD);
   assign is_errw = (rk == 2'b11) && (dat == 16'hFEFE);
   assign is_bad  = is_k && !(is_idle || is_sof || is_eof || is_errw);

   // Link sync: count consecutive commas while down; ERRW/BADK drop the link
   always_comb begin
      link_d  = o_link_up;
      comma_d = comma_cnt;
      if (i_rx_valid) begin
         if (is_errw || is_bad) begin
            link_d  = 1'b0;
            comma_d = '0;
         end else if (!o_link_up) begin
            if (is_idle) begin
               if (9'(comma_cnt) + 9'd1 >= 9'(SYNC_CNT)) begin
                  link_d  = 1'b1;
                  comma_d = '0;
               end else begin
                  comma_d = comma_cnt + CW'(1);
               end
            end else begin
               comma_d = '0;
            end
         end
      end
   end

   // Per-word frame event decode; link-loss words are K-characters and land in the framing cases
   always_comb begin
      err_c  = 1'b0;
      code_c = 2'd0;
      done_c = 1'b0;
      emit_c = 1'b0;
      load_c = 1'b0;
      if (i_rx_valid && o_link_up) begin
         case (state)
            S_LEN: begin
               if (is_k) begin
                  err_c  = 1'b1;
                  code_c = ERR_FRM;
               end else if ((dat == '0) || (32'(dat) > MAX_LEN)) begin
                  err_c  = 1'b1;
                  code_c = ERR_LEN;
               end else begin
                  load_c = 1'b1;
               end
            end
            S_DATA: begin
               if (is_k) begin
                  err_c  = 1'b1;
                  code_c = ERR_FRM;
               end else begin
                  emit_c = 1'b1;
               end
            end
            S_CHK: begin
               if (is_k) begin
                  err_c  = 1'b1;
                  code_c = ERR_FRM;
               end else if (dat != csum) begin
                  err_c  = 1'b1;
                  code_c = ERR_CHK;
               end
            end
            S_EOF: begin
               if (is_eof) begin
                  done_c = 1'b1;
               end else begin
                  err_c  = 1'b1;
                  code_c = ERR_FRM;
               end
            end
            default: ;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst || i_soft_rst) state <= S_IDLE;
      else                   state <= state_d;
   end

   // Next state
   always_comb begin
      state_d = state;
      if (!o_link_up) begin
         state_d = S_IDLE;
      end else if (i_rx_valid) begin
         if (err_c || done_c) begin
            state_d = S_IDLE;
         end else begin
            case (state)
               S_IDLE:  if (is_sof) state_d = S_LEN;
               S_LEN:   state_d = S_DATA;
               S_DATA:  if (rem == DW'(1)) state_d = S_CHK;
               S_CHK:   state_d = S_EOF;
               default: state_d = S_IDLE;
            endcase
         end
      end
   end

   // Output next values
   always_comb begin
      data_d = o_data;
      dv_d   = emit_c;
      sof_d  = emit_c && first;
      eof_d  = emit_c && (rem == DW'(1));
      done_d = done_c;
      err_d  = err_c;
      code_d = o_err_code;
      fcnt_d = o_frame_cnt;
      ecnt_d = o_err_cnt;
      if (emit_c) data_d = dat;
      if (err_c) code_d = code_c;
      if (done_c && (o_frame_cnt != '1)) fcnt_d = o_frame_cnt + 32'd1;
      if (err_c && (o_err_cnt != '1)) ecnt_d = o_err_cnt + 16'd1;
   end

   // Link, datapath and per-word output registers
   always_ff @(posedge clk) begin
      if (rst || i_soft_rst) begin
         o_link_up    <= 1'b0;
         comma_cnt    <= '0;
         rem          <= '0;
         csum         <= '0;
         first        <= 1'b0;
         o_data       <= '0;
         o_data_valid <= 1'b0;
         o_sof        <= 1'b0;
         o_eof        <= 1'b0;
         o_frame_done <= 1'b0;
         o_frame_err  <= 1'b0;
         o_err_code   <= 2'd0;
      end else begin
         o_link_up    <= link_d;
         comma_cnt    <= comma_d;
         o_data       <= data_d;
         o_data_valid <= dv_d;
         o_sof        <= sof_d;
         o_eof        <= eof_d;
         o_frame_done <= done_d;
         o_frame_err  <= err_d;
         o_err_code   <= code_d;
         if (load_c) begin
            rem   <= dat;
            csum  <= '0;
            first <= 1'b1;
         end else if (emit_c) begin
            rem   <= rem - DW'(1);
            csum  <= csum + dat;
            first <= 1'b0;
         end
      end
   end

   // Statistics survive a soft reset
   always_ff @(posedge clk) begin
      if (rst) begin
         o_frame_cnt <= '0;
         o_err_cnt   <= '0;
      end else if (!i_soft_rst) begin
         o_frame_cnt <= fcnt_d;
         o_err_cnt   <= ecnt_d;
      end
   end

endmodule

// File: tb/tb_tlk2711_rx_frame.sv
// Bench for tlk2711_rx_frame: hand-derived vector table, directed corner sequences,
// then random traffic against a frame-position reference model.
module tb_tlk2711_rx_frame;

   localparam int unsigned TB_MAX  = 8;
   localparam int unsigned TB_SYNC = 4;
   localparam logic [17:0] IDLEW = 18'h1C5BC;
   localparam logic [17:0] SOFW  = 18'h100FB;
   localparam logic [17:0] EOFW  = 18'h100FD;
   localparam logic [17:0] ERRWW = 18'h3FEFE;

   logic        clk, rst, i_soft_rst, i_rx_valid;
   logic [17:0] i_rx_data;
   logic        o_link_up, o_data_valid, o_sof, o_eof, o_frame_done, o_frame_err;
   logic [15:0] o_data;
   logic [1:0]  o_err_code;
   logic [31:0] o_frame_cnt;
   logic [15:0] o_err_cnt;

   tlk2711_rx_frame #(.MAX_LEN(TB_MAX), .SYNC_CNT(TB_SYNC)) dut (
      .clk(clk), .rst(rst), .i_soft_rst(i_soft_rst), .i_rx_valid(i_rx_valid),
      .i_rx_data(i_rx_data), .o_link_up(o_link_up), .o_data(o_data),
      .o_data_valid(o_data_valid), .o_sof(o_sof), .o_eof(o_eof),
      .o_frame_done(o_frame_done), .o_frame_err(o_frame_err), .o_err_code(o_err_code),
      .o_frame_cnt(o_frame_cnt), .o_err_cnt(o_err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int dv_seen = 0;

   // Reference model: position within frame (-1 = outside, 0 = length, 1..L payload, L+1 checksum, L+2 EOF)
   logic        m_link = 1'b0;
   int          m_commas = 0;
   int          m_pos = -1;
   int          m_len = 0;
   logic [15:0] m_pay[$];
   logic [31:0] m_fcnt = '0;
   logic [15:0] m_ecnt = '0;
   logic [1:0]  m_code = '0;
   logic [15:0] m_data = '0;
   logic        e_dv, e_sof, e_eof, e_done, e_err;

   logic [15:0] tx_pay[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input logic r, input logic sr, input logic v, input logic [17:0] w);
      logic [1:0]  rk;
      logic [15:0] d;
      bit          is_eof, isk, kill, was;
      int          code;
      int unsigned s;
      rk = w[17:16];
      d  = w[15:0];
      code = 0;
      {e_dv, e_sof, e_eof, e_done, e_err} = '0;
      if (r || sr) begin
         m_link = 1'b0; m_commas = 0; m_pos = -1; m_code = '0; m_data = '0;
         if (r) begin
            m_fcnt = '0; m_ecnt = '0;
         end
         return;
      end
      if (!v) return;
      is_eof = (w == EOFW);
      isk    = (rk != 2'b00);
      kill   = (w == ERRWW) || (isk && w != IDLEW && w != SOFW && w != EOFW);
      was    = m_link;
      if (kill) begin
         m_link = 1'b0; m_commas = 0;
      end else if (!m_link) begin
         if (w == IDLEW) begin
            m_commas++;
            if (m_commas >= int'(TB_SYNC)) begin
               m_link = 1'b1; m_commas = 0;
            end
         end else begin
            m_commas = 0;
         end
      end
      if (!was) return;
      if (m_pos < 0) begin
         if (w == SOFW) begin
            m_pos = 0; m_pay.delete();
         end
      end else if (m_pos == 0) begin
         if (isk) code = 3;
         else if (d == 16'd0 || int'(d) > int'(TB_MAX)) code = 1;
         else begin
            m_len = int'(d); m_pos = 1;
         end
      end else if (m_pos <= m_len) begin
         if (isk) code = 3;
         else begin
            e_dv = 1'b1; e_sof = (m_pos == 1); e_eof = (m_pos == m_len);
            m_data = d; m_pay.push_back(d); m_pos++;
         end
      end else if (m_pos == m_len + 1) begin
         if (isk) code = 3;
         else begin
            s = 0;
            foreach (m_pay[i]) s += m_pay[i];
            if (d == s[15:0]) m_pos++;
            else code = 2;
         end
      end else begin
         if (is_eof) begin
            e_done = 1'b1; m_pos = -1;
            if (m_fcnt != '1) m_fcnt++;
         end else code = 3;
      end
      if (code != 0) begin
         e_err = 1'b1; m_code = 2'(code); m_pos = -1;
         if (m_ecnt != '1) m_ecnt++;
      end
   endtask

   task automatic apply(input logic r, input logic sr, input logic v, input logic [17:0] w);
      rst = r; i_soft_rst = sr; i_rx_valid = v; i_rx_data = w;
      @(posedge clk);
      #1;
      model_step(r, sr, v, w);
      if (o_data_valid) dv_seen++;
   endtask

   task automatic check_model();
      chk("ctl", 64'({o_link_up, o_data_valid, o_sof, o_eof, o_frame_done, o_frame_err, o_err_code}),
          64'({m_link, e_dv, e_sof, e_eof, e_done, e_err, m_code}));
      chk("data", 64'(o_data), 64'(m_data));
      chk("fcnt", 64'(o_frame_cnt), 64'(m_fcnt));
      chk("ecnt", 64'(o_err_cnt), 64'(m_ecnt));
   endtask

   task automatic cycle(input logic r, input logic sr, input logic v, input logic [17:0] w);
      apply(r, sr, v, w);
      check_model();
   endtask

   task automatic word(input logic [17:0] w, input int pct);
      while (int'($urandom_range(0, 99)) < pct) cycle(1'b0, 1'b0, 1'b0, 18'($urandom));
      cycle(1'b0, 1'b0, 1'b1, w);
   endtask

   task automatic sync();
      repeat (TB_SYNC) cycle(1'b0, 1'b0, 1'b1, IDLEW);
   endtask

   task automatic send_frame(input int pct, input bit bad, input int cut);
      int unsigned s;
      s = 0;
      word(SOFW, pct);
      word({2'b00, 16'(tx_pay.size())}, pct);
      for (int i = 0; i < tx_pay.size(); i++) begin
         if (cut > 0 && i == cut) begin
            word(SOFW, pct);
            return;
         end
         word({2'b00, tx_pay[i]}, pct);
         s += tx_pay[i];
      end
      word({2'b00, 16'(s) ^ (bad ? 16'h0001 : 16'h0000)}, pct);
      word(EOFW, pct);
   endtask

   task automatic fixed_payload();
      tx_pay.delete();
      tx_pay.push_back(16'h0001);
      tx_pay.push_back(16'h0002);
      tx_pay.push_back(16'hFFFF);
   endtask

   typedef struct {
      logic        r;
      logic        v;
      logic [17:0] w;
      logic [7:0]  ctl;   // {link, dv, sof, eof, done, err, code}
      logic [15:0] data;
      logic [31:0] fcnt;
      logic [15:0] ecnt;
   } vec_t;

   vec_t tbl[$];

   initial begin
      rst = 1'b1; i_soft_rst = 1'b0; i_rx_valid = 1'b0; i_rx_data = '0;

      // Sync, good frame, checksum-error frame, then ERRW drops link
      tbl.push_back('{1'b1, 1'b0, 18'h0,       8'h00, 16'h0000, 32'd0, 16'd0});
      tbl.push_back('{1'b0, 1'b1, IDLEW,       8'h00, 16'h0000, 32'd0, 16'd0});
      tbl.push_back('{1'b0, 1'b1, IDLEW,       8'h00, 16'h0000, 32'd0, 16'd0});
      tbl.push_back('{1'b0, 1'b1, IDLEW,       8'h00, 16'h0000, 32'd0, 16'd0});
      tbl.push_back('{1'b0, 1'b1, IDLEW,       8'h80, 16'h0000, 32'd0, 16'd0});
      tbl.push_back('{1'b0, 1'b1, SOFW,        8'h80, 16'h0000, 32'd0, 16'd0});
      tbl.push_back('{1'b0, 1'b1, 18'h00003,   8'h80, 16'h0000, 32'd0, 16'd0});
      tbl.push_back('{1'b0, 1'b1, 18'h00001,   8'hE0, 16'h0001, 32'd0, 16'd0});
      tbl.push_back('{1'b0, 1'b1, 18'h00002,   8'hC0, 16'h0002, 32'd0, 16'd0});
      tbl.push_back('{1'b0, 1'b1, 18'h0FFFF,   8'hD0, 16'hFFFF, 32'd0, 16'd0});
      tbl.push_back('{1'b0, 1'b1, 18'h00002,   8'h80, 16'hFFFF, 32'd0, 16'd0});
      tbl.push_back('{1'b0, 1'b1, EOFW,        8'h88, 16'hFFFF, 32'd1, 16'd0});
      tbl.push_back('{1'b0, 1'b1, SOFW,        8'h80, 16'hFFFF, 32'd1, 16'd0});
      tbl.push_back('{1'b0, 1'b1, 18'h00003,   8'h80, 16'hFFFF, 32'd1, 16'd0});
      tbl.push_back('{1'b0, 1'b1, 18'h00001,   8'hE0, 16'h0001, 32'd1, 16'd0});
      tbl.push_back('{1'b0, 1'b1, 18'h00002,   8'hC0, 16'h0002, 32'd1, 16'd0});
      tbl.push_back('{1'b0, 1'b1, 18'h0FFFF,   8'hD0, 16'hFFFF, 32'd1, 16'd0});
      tbl.push_back('{1'b0, 1'b1, 18'h00003,   8'h86, 16'hFFFF, 32'd1, 16'd1});
      tbl.push_back('{1'b0, 1'b1, EOFW,        8'h82, 16'hFFFF, 32'd1, 16'd1});
      tbl.push_back('{1'b0, 1'b1, ERRWW,       8'h02, 16'hFFFF, 32'd1, 16'd1});

      foreach (tbl[i]) begin
         apply(tbl[i].r, 1'b0, tbl[i].v, tbl[i].w);
         chk($sformatf("tbl%0d_ctl", i),
             64'({o_link_up, o_data_valid, o_sof, o_eof, o_frame_done, o_frame_err, o_err_code}),
             64'(tbl[i].ctl));
         chk($sformatf("tbl%0d_data", i), 64'(o_data), 64'(tbl[i].data));
         chk($sformatf("tbl%0d_fcnt", i), 64'(o_frame_cnt), 64'(tbl[i].fcnt));
         chk($sformatf("tbl%0d_ecnt", i), 64'(o_err_cnt), 64'(tbl[i].ecnt));
      end

      // Length errors: L=0 and L=MAX_LEN+1
      sync();
      word(SOFW, 0);
      word(18'h00000, 0);
      chk("len0_err", 64'({o_frame_err, o_err_code}), 64'(3'b101));
      word(SOFW, 0);
      word({2'b00, 16'(TB_MAX + 1)}, 0);
      chk("lenmax_err", 64'({o_frame_err, o_err_code}), 64'(3'b101));

      // SOF inside payload is a framing error, then recovery with a good frame
      word(SOFW, 0);
      word(18'h00003, 0);
      word(18'h00001, 0);
      word(SOFW, 0);
      chk("sof_in_data", 64'({o_frame_err, o_err_code}), 64'(3'b111));
      fixed_payload();
      send_frame(0, 1'b0, 0);
      chk("recover_done", 64'(o_frame_done), 64'(1));
      chk("recover_fcnt", 64'(o_frame_cnt), 64'(2));

      // Same frame with ~50% stalls
      dv_seen = 0;
      send_frame(50, 1'b0, 0);
      chk("stall_dv_count", 64'(dv_seen), 64'(3));
      chk("stall_fcnt", 64'(o_frame_cnt), 64'(3));

      // Hard reset after two payload words
      word(SOFW, 0);
      word(18'h00003, 0);
      word(18'h00001, 0);
      word(18'h00002, 0);
      cycle(1'b1, 1'b0, 1'b1, 18'h0FFFF);
      chk("rst_outputs", 64'({o_link_up, o_data_valid, o_sof, o_eof, o_frame_done, o_frame_err, o_err_code}), 64'(0));
      chk("rst_cnts", 64'({o_frame_cnt, o_err_cnt}), 64'(0));

      // Soft reset after two payload words keeps counters
      sync();
      send_frame(0, 1'b0, 0);
      word(SOFW, 0);
      word(18'h00003, 0);
      word(18'h00001, 0);
      word(18'h00002, 0);
      cycle(1'b0, 1'b1, 1'b1, 18'h0FFFF);
      chk("srst_link_err", 64'({o_link_up, o_frame_err, o_data_valid}), 64'(0));
      chk("srst_fcnt", 64'(o_frame_cnt), 64'(1));
      chk("srst_ecnt", 64'(o_err_cnt), 64'(0));

      // Random traffic against the model
      for (int it = 0; it < 400; it++) begin
         int a;
         a = int'($urandom_range(0, 99));
         if (!m_link && a < 85) sync();
         if (a < 55) begin
            tx_pay.delete();
            repeat (int'($urandom_range(1, TB_MAX))) tx_pay.push_back(16'($urandom));
            send_frame(30, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0) ? 1 : 0);
         end else if (a < 65) begin
            word(18'($urandom), 20);
         end else if (a < 73) begin
            word(SOFW, 20);
            word({2'b00, ($urandom_range(0, 1) == 0) ? 16'd0 : 16'(TB_MAX + $urandom_range(1, 100))}, 20);
         end else if (a < 80) begin
            word(ERRWW, 0);
         end else if (a < 84) begin
            cycle(1'b0, 1'b1, 1'b1, IDLEW);
         end else if (a < 85) begin
            cycle(1'b1, 1'b0, 1'b0, IDLEW);
         end else begin
            repeat (int'($urandom_range(1, 5))) word(IDLEW, 30);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tlk2711_rx_frame.md
# tlk2711_rx_frame

Receive-side frame decoder for the TLK2711 link, sitting in the system `clk` domain directly downstream of the rx clock-domain-crossing FIFO. It consumes the 18-bit character stream `{RKMSB, RKLSB, data[15:0]}` and establishes link sync from idle commas. It delineates SOF/length/payload/checksum/EOF frames and emits the payload as a valid-qualified 16-bit stream with per-frame success/error pulses and counters.

## Interface
- `MAX_LEN`, 1024: maximum payload words per frame; range 1..65535.
- `SYNC_CNT`, 4: consecutive idle commas required to declare link up; range 1..255.
- `clk`  in  1  system clock; one clock, all logic in this domain.
- `rst`  in  1  synchronous, active-high reset.
- `i_soft_rst`  in  1  synchronous, active-high; same effect as `rst`, except counters are preserved.
- `i_rx_valid`  in  1  input word present this cycle; low = stall, all state holds.
- `i_rx_data`  in  18  `[17]`=RKMSB, `[16]`=RKLSB, `[15:0]`=data.
- `o_link_up`  out  1  link synchronised.
- `o_data`  out  16  payload word.
- `o_data_valid`  out  1  `o_data` is a payload word.
- `o_sof`  out  1  with `o_data_valid`: first payload word of the frame.
- `o_eof`  out  1  with `o_data_valid`: last payload word of the frame.
- `o_frame_done`  out  1  one-cycle pulse: frame received without error.
- `o_frame_err`  out  1  one-cycle pulse: frame aborted or failed.
- `o_err_code`  out  2  valid with `o_frame_err`: 1=length, 2=checksum, 3=framing.
- `o_frame_cnt`  out  32  good frames; saturates at all-ones.
- `o_err_cnt`  out  16  errored frames; saturates at all-ones.

## Operation
- Character classes (valid word only):
  - IDLE = rk 2'b01, data 0xC5BC.
  - SOF = rk 2'b01, data 0x00FB.
  - EOF = rk 2'b01, data 0x00FD.
  - ERRW = rk 2'b11, data 0xFEFE.
  - DATA = rk 2'b00.
  - Any other rk≠00 is BADK.
- Link sync:
  - A comma counter increments on each IDLE and clears on any non-IDLE word while the link is down.
  - Reaching `SYNC_CNT` sets `o_link_up`.
  - ERRW or BADK clears `o_link_up` and the counter.
- FSM states: S_IDLE, S_LEN, S_DATA, S_CHK, S_EOF. State changes only on valid words and only while `o_link_up`. Link loss forces S_IDLE.
- S_IDLE:
  - SOF → S_LEN.
  - Anything else is ignored.
- S_LEN:
  - Word is the payload length L, L = data[15:0].
  - L=0 or L>`MAX_LEN` → error code 1, go to S_IDLE.
  - Otherwise, load the remaining-word counter with L, clear the checksum, go to S_DATA.
  - A K-character (any rk≠00) here → error code 3.
- S_DATA:
  - Each DATA word is emitted on `o_data`, added to the 16-bit checksum (unsigned sum, modulo 2^16), and decrements the remaining-word counter.
  - `o_sof` is set on the first word; `o_eof` is set when the remaining count is 1.
  - After the last word → S_CHK.
- S_CHK:
  - A DATA word equal to the accumulated sum → S_EOF.
  - A DATA word with a different value → error code 2.
  - A K-character here → error code 3.
- S_EOF:
  - EOF → `o_frame_done`, increment `o_frame_cnt`, go to S_IDLE.
  - Anything else → error code 3.
- Any K-character in S_LEN, S_DATA or S_CHK, including SOF or EOF, is a framing error (code 3) → S_IDLE.
- On every error: pulse `o_frame_err` with `o_err_code`, increment `o_err_cnt`, go to S_IDLE.
- Link loss while in S_LEN..S_EOF is also error code 3.
- Payload already emitted is not retracted. The downstream consumer discards the frame on `o_frame_err`.
- An error and a new SOF never occur in the same cycle: the SOF that caused an error is consumed and not restarted.

## Timing
- All outputs are registered. Latency from valid input word to the corresponding output is 1 cycle.
- `o_link_up` rises in the cycle after the `SYNC_CNT`-th consecutive IDLE is sampled.
- `o_frame_done` / `o_frame_err` assert in the cycle after the terminating word. Both are one cycle wide and never assert together.
- Stall cycles (`i_rx_valid`=0):
  - All single-cycle outputs (`o_data_valid`, `o_sof`, `o_eof`, pulses) are 0.
  - The FSM, counters and checksum hold.
- Reset values: all outputs 0, `o_err_code`=0, FSM in S_IDLE, comma counter 0.
- `i_soft_rst` has the same effect, but `o_frame_cnt` and `o_err_cnt` hold their values.
- Reset asserted mid-frame:
  - Next cycle all outputs are 0 and the FSM is in S_IDLE.
  - No error pulse is generated.
- L=1 frame: the single payload word carries `o_sof`=`o_eof`=1.

## Test plan
- Link sync: 3 IDLE words → `o_link_up`=0; 4th IDLE → `o_link_up`=1 one cycle later. ERRW → `o_link_up`=0 next cycle.
- Good frame: sync, then SOF, L=3, payload 0x0001/0x0002/0xFFFF, checksum 0x0002, EOF.
  - Three `o_data_valid` pulses; `o_sof` on the first word, `o_eof` on the third.
  - One `o_frame_done` pulse; `o_frame_cnt`=1.
- Checksum error: same frame with checksum word 0x0003 → `o_frame_err`, `o_err_code`=2, `o_err_cnt`=1, no `o_frame_done`.
- Length and framing errors:
  - L=0 → code 1.
  - L=`MAX_LEN`+1 → code 1.
  - SOF received in S_DATA → code 3.
  - Every error returns to S_IDLE; a following good frame completes normally.
- Stalls: the good frame with `i_rx_valid` low on random cycles (about 50%) → identical payload and pulses, with no output activity on stall cycles.
- Reset mid-frame:
  - Assert `rst` after 2 payload words → all outputs 0, `o_link_up`=0, no pulse.
  - Assert `i_soft_rst` instead → counters retained.
